bdm_macro_sequencer: RTL and testbench

Sequences the single-wire BDM engine on behalf of one requester. It accepts high-level macro-ops such as "read byte at address" and expands each into a fixed series of engine primitives (WRITE, READ, DELAY, START_MCU, STOP_MCU). It pushes the bytes that come back into the reply FIFO. It sits between the command FIFO front end and the `bdm` engine, replacing raw per-primitive command streams from the host.

---
 rtl/bdm_pkg.sv | 41 ++++
 rtl/bdm_macro_rom.sv | 74 +++++++
 rtl/bdm_macro_sequencer.sv | 146 ++++++++++++++
 tb/tb_bdm_macro_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdm_pkg.sv
// Shared constants for the BDM macro sequencer: primitive codes, macro opcodes,
// BDM command bytes and reply error bytes.
package bdm_pkg;

  typedef enum logic [3:0] {
    PRIM_NONE      = 4'd0,
    PRIM_READ      = 4'd1,
    PRIM_WRITE     = 4'd2,
    PRIM_START_MCU = 4'd3,
    PRIM_STOP_MCU  = 4'd4,
    PRIM_DELAY     = 4'd6
  } prim_cmd_e;

  typedef enum logic [2:0] {
    OP_NOP           = 3'd0,
    OP_READ_BYTE     = 3'd1,
    OP_WRITE_BYTE    = 3'd2,
    OP_BACKGROUND    = 3'd3,
    OP_READ_STATUS   = 3'd4,
    OP_WRITE_CONTROL = 3'd5,
    OP_POWER_CYCLE   = 3'd6,
    OP_RESERVED      = 3'd7
  } macro_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_e;

  localparam logic [7:0] BDM_READ_BYTE     = 8'hE0;
  localparam logic [7:0] BDM_WRITE_BYTE    = 8'hC0;
  localparam logic [7:0] BDM_BACKGROUND    = 8'h90;
  localparam logic [7:0] BDM_READ_STATUS   = 8'hE4;
  localparam logic [7:0] BDM_WRITE_CONTROL = 8'hC4;

  localparam logic [7:0] RSP_TIMEOUT_BYTE  = 8'hEE;
  localparam logic [7:0] RSP_BAD_OP_BYTE   = 8'hEF;

endpackage

// File: rtl/bdm_macro_rom.sv
// Combinational expansion table: (op, step, addr, data) -> primitive to issue,
// plus a flag marking the final step of the macro.
module bdm_macro_rom
  import bdm_pkg::*;
#(
  parameter logic [7:0] DELAY_ARG = 8'd16
) (
  input  logic [2:0]  op,
  input  logic [2:0]  step,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [3:0]  cmd,
  output logic [7:0]  pdata,
  output logic        last
);

  always_comb begin
    cmd   = PRIM_NONE;
    pdata = 8'h00;
    last  = 1'b1;
    case (macro_op_e'(op))
      OP_READ_BYTE: begin
        last = (step == 3'd4);
        case (step)
          3'd0:    begin cmd = PRIM_WRITE; pdata = BDM_READ_BYTE; end
          3'd1:    begin cmd = PRIM_WRITE; pdata = addr[15:8];    end
          3'd2:    begin cmd = PRIM_WRITE; pdata = addr[7:0];     end
          3'd3:    begin cmd = PRIM_DELAY; pdata = DELAY_ARG;     end
          default: begin cmd = PRIM_READ;  pdata = 8'h00;         end
        endcase
      end
      OP_WRITE_BYTE: begin
        last = (step == 3'd4);
        case (step)
          3'd0:    begin cmd = PRIM_WRITE; pdata = BDM_WRITE_BYTE; end
          3'd1:    begin cmd = PRIM_WRITE; pdata = addr[15:8];     end
          3'd2:    begin cmd = PRIM_WRITE; pdata = addr[7:0];      end
          3'd3:    begin cmd = PRIM_WRITE; pdata = data;           end
          default: begin cmd = PRIM_DELAY; pdata = DELAY_ARG;      end
        endcase
      end
      OP_BACKGROUND: begin
        last = (step == 3'd1);
        if (step == 3'd0) begin cmd = PRIM_WRITE; pdata = BDM_BACKGROUND; end
        else              begin cmd = PRIM_DELAY; pdata = DELAY_ARG;      end
      end
      OP_READ_STATUS: begin
        last = (step == 3'd1);
        if (step == 3'd0) begin cmd = PRIM_WRITE; pdata = BDM_READ_STATUS; end
        else              begin cmd = PRIM_READ;  pdata = 8'h00;           end
      end
      OP_WRITE_CONTROL: begin
        last = (step == 3'd1);
        if (step == 3'd0) begin cmd = PRIM_WRITE; pdata = BDM_WRITE_CONTROL; end
        else              begin cmd = PRIM_WRITE; pdata = data;              end
      end
      OP_POWER_CYCLE: begin
        last = (step == 3'd3);
        case (step)
          3'd0:         cmd = PRIM_STOP_MCU;
          3'd1, 3'd2:   begin cmd = PRIM_DELAY; pdata = DELAY_ARG; end
          default:      cmd = PRIM_START_MCU;
        endcase
      end
      // NOP and the reserved opcode expand to nothing
      default: begin
        cmd   = PRIM_NONE;
        pdata = 8'h00;
        last  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bdm_macro_sequencer.sv
// Expands latched macro-ops into BDM engine primitives, one at a time, and
// forwards read bytes (or error bytes) to the reply FIFO.
//
// state | meaning
// IDLE  | waiting for a macro handshake
// ISSUE | prim_cmd/prim_data driven for this single cycle
// GAP   | engine settles; prim_ready ignored
// WAIT  | waiting for prim_ready (or timeout) to advance the step
module bdm_macro_sequencer
  import bdm_pkg::*;
#(
  parameter logic [7:0]  DELAY_ARG = 8'd16,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mc_valid,
  input  logic [2:0]  mc_op,
  input  logic [15:0] mc_addr,
  input  logic [7:0]  mc_data,
  output logic        mc_ready,
  output logic [3:0]  prim_cmd,
  output logic [7:0]  prim_data,
  input  logic        prim_ready,
  input  logic        prim_rvalid,
  input  logic [7:0]  prim_rdata,
  output logic        rsp_wr_en,
  output logic [7:0]  rsp_data,
  input  logic        rsp_full,
  output logic        busy,
  output logic        err_timeout
);

  seq_state_e  state, state_nxt;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [2:0]  step_q;
  logic        last_q;
  logic [15:0] tmo_cnt;

  logic        accept;
  logic        tmo_hit;
  logic [2:0]  rom_op;
  logic [2:0]  rom_step;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rom_cmd;
  logic [7:0]  rom_pdata;
  logic        rom_last;

  assign mc_ready = (state == ST_IDLE) && !rsp_full;
  assign accept   = mc_valid && mc_ready;
  assign tmo_hit  = (tmo_cnt == 16'd0);

  // The ROM always looks up the primitive that the next ISSUE will drive.
  assign rom_op   = (state == ST_IDLE) ? mc_op   : op_q;
  assign rom_step = (state == ST_IDLE) ? 3'd0    : step_q + 3'd1;
  assign rom_addr = (state == ST_IDLE) ? mc_addr : addr_q;
  assign rom_data = (state == ST_IDLE) ? mc_data : data_q;

  bdm_macro_rom #(.DELAY_ARG(DELAY_ARG)) u_rom (
    .op    (rom_op),
    .step  (rom_step),
    .addr  (rom_addr),
    .data  (rom_data),
    .cmd   (rom_cmd),
    .pdata (rom_pdata),
    .last  (rom_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && (rom_cmd != PRIM_NONE)) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (prim_ready)   state_nxt = last_q ? ST_IDLE : ST_ISSUE;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prim_cmd    <= PRIM_NONE;
      prim_data   <= 8'h00;
      rsp_wr_en   <= 1'b0;
      rsp_data    <= 8'h00;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      op_q        <= 3'd0;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      step_q      <= 3'd0;
      last_q      <= 1'b0;
      tmo_cnt     <= 16'h0000;
    end else begin
      prim_cmd  <= PRIM_NONE;
      prim_data <= 8'h00;
      rsp_wr_en <= 1'b0;
      busy      <= (state_nxt != ST_IDLE);

      if (state_nxt == ST_ISSUE) begin
        prim_cmd  <= rom_cmd;
        prim_data <= rom_pdata;
        last_q    <= rom_last;
      end

      if (accept) begin
        op_q   <= mc_op;
        addr_q <= mc_addr;
        data_q <= mc_data;
        step_q <= 3'd0;
      end else if (state == ST_WAIT && prim_ready) begin
        step_q <= step_q + 3'd1;
      end

      // Down-counter: reloaded while issuing, expires at zero during WAIT.
      if (state == ST_ISSUE)
        tmo_cnt <= TIMEOUT;
      else if ((state == ST_GAP || state == ST_WAIT) && !tmo_hit)
        tmo_cnt <= tmo_cnt - 16'd1;

      if (state == ST_WAIT && !prim_ready && tmo_hit) begin
        err_timeout <= 1'b1;
        rsp_wr_en   <= 1'b1;
        rsp_data    <= RSP_TIMEOUT_BYTE;
      end else if (accept && mc_op == OP_RESERVED) begin
        rsp_wr_en <= 1'b1;
        rsp_data  <= RSP_BAD_OP_BYTE;
      end else if (prim_rvalid) begin
        rsp_wr_en <= 1'b1;
        rsp_data  <= prim_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bdm_macro_sequencer.sv
// Directed bench for bdm_macro_sequencer: a table of macros with expected
// primitive streams and replies, plus hand-written timeout/backpressure/reset cases.
module tb_bdm_macro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mc_valid = 1'b0;
  logic [2:0]  mc_op = 3'd0;
  logic [15:0] mc_addr = 16'h0;
  logic [7:0]  mc_data = 8'h0;
  logic        mc_ready;
  logic [3:0]  prim_cmd;
  logic [7:0]  prim_data;
  logic        prim_ready;
  logic        prim_rvalid;
  logic [7:0]  prim_rdata;
  logic        rsp_wr_en;
  logic [7:0]  rsp_data;
  logic        rsp_full = 1'b0;
  logic        busy;
  logic        err_timeout;

  bdm_macro_sequencer #(.DELAY_ARG(8'h10), .TIMEOUT(16'd100)) dut (
    .clk(clk), .rst(rst),
    .mc_valid(mc_valid), .mc_op(mc_op), .mc_addr(mc_addr), .mc_data(mc_data),
    .mc_ready(mc_ready),
    .prim_cmd(prim_cmd), .prim_data(prim_data),
    .prim_ready(prim_ready), .prim_rvalid(prim_rvalid), .prim_rdata(prim_rdata),
    .rsp_wr_en(rsp_wr_en), .rsp_data(rsp_data), .rsp_full(rsp_full),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  logic [11:0] prim_log[$];
  logic [7:0]  reply_q[$];
  logic [7:0]  eng_rdata = 8'h00;
  logic        stall_en = 1'b0;
  int          stall_idx = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Engine model: drops prim_ready on each primitive, returns it two cycles
  // later (with the read byte for READ), or never when stalled.
  initial begin
    logic was_read;
    prim_ready  = 1'b1;
    prim_rvalid = 1'b0;
    prim_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      prim_rvalid = 1'b0;
      if (!rst && prim_cmd != 4'd0) begin
        prim_log.push_back({prim_cmd, prim_data});
        if (!prim_ready) viol++;
        was_read   = (prim_cmd == 4'd1);
        prim_ready = 1'b0;
        @(negedge clk);
        if (prim_cmd != 4'd0) viol++;
        if (!(stall_en && (prim_log.size() - 1 >= stall_idx))) begin
          @(negedge clk);
          prim_ready  = 1'b1;
          prim_rvalid = was_read;
          prim_rdata  = eng_rdata;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rsp_wr_en) begin
        reply_q.push_back(rsp_data);
        if (rsp_full) viol++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]       op;
    logic [15:0]      addr;
    logic [7:0]       data;
    logic [7:0]       rdata;
    int               n_prim;
    logic [4:0][3:0]  cmds;
    logic [4:0][7:0]  pdat;
    int               n_rep;
    logic [7:0]       rep;
  } vec_t;

  vec_t vecs[8];

  task automatic send_macro(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data);
    bit ok;
    ok = 1'b0;
    mc_op = op; mc_addr = addr; mc_data = data; mc_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (mc_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("handshake_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1 mc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_idle_bound"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;

    vecs[0] = '{3'd1, 16'h1234, 8'h00, 8'h5A, 5, {4'd1,4'd6,4'd2,4'd2,4'd2},
                {8'h00,8'h10,8'h34,8'h12,8'hE0}, 1, 8'h5A};
    vecs[1] = '{3'd2, 16'h0080, 8'hA5, 8'h00, 5, {4'd6,4'd2,4'd2,4'd2,4'd2},
                {8'h10,8'hA5,8'h80,8'h00,8'hC0}, 0, 8'h00};
    vecs[2] = '{3'd6, 16'h0000, 8'h00, 8'h00, 4, {4'd0,4'd3,4'd6,4'd6,4'd4},
                {8'h00,8'h00,8'h10,8'h10,8'h00}, 0, 8'h00};
    vecs[3] = '{3'd3, 16'hFFFF, 8'h11, 8'h00, 2, {4'd0,4'd0,4'd0,4'd6,4'd2},
                {8'h00,8'h00,8'h00,8'h10,8'h90}, 0, 8'h00};
    vecs[4] = '{3'd4, 16'h0000, 8'h00, 8'h3C, 2, {4'd0,4'd0,4'd0,4'd1,4'd2},
                {8'h00,8'h00,8'h00,8'h00,8'hE4}, 1, 8'h3C};
    vecs[5] = '{3'd5, 16'h0000, 8'h77, 8'h00, 2, {4'd0,4'd0,4'd0,4'd2,4'd2},
                {8'h00,8'h00,8'h00,8'h77,8'hC4}, 0, 8'h00};
    vecs[6] = '{3'd0, 16'hABCD, 8'h55, 8'h00, 0, '0, '0, 0, 8'h00};
    vecs[7] = '{3'd7, 16'h0000, 8'h00, 8'h00, 0, '0, '0, 1, 8'hEF};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_prim_cmd", {28'd0, prim_cmd}, 32'd0);
    chk("rst_prim_data", {24'd0, prim_data}, 32'd0);
    chk("rst_rsp_wr_en", {31'd0, rsp_wr_en}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mc_ready", {31'd0, mc_ready}, 32'd1);

    // table-driven macros
    for (int v = 0; v < 8; v++) begin
      prim_log.delete();
      reply_q.delete();
      eng_rdata = vecs[v].rdata;
      send_macro(vecs[v].op, vecs[v].addr, vecs[v].data);
      wait_idle($sformatf("v%0d", v));
      chk($sformatf("v%0d_nprim", v), prim_log.size(), vecs[v].n_prim);
      for (int k = 0; k < vecs[v].n_prim && k < prim_log.size(); k++) begin
        chk($sformatf("v%0d_cmd%0d", v, k), {28'd0, prim_log[k][11:8]}, {28'd0, vecs[v].cmds[k]});
        chk($sformatf("v%0d_dat%0d", v, k), {24'd0, prim_log[k][7:0]}, {24'd0, vecs[v].pdat[k]});
      end
      chk($sformatf("v%0d_nrep", v), reply_q.size(), vecs[v].n_rep);
      if (vecs[v].n_rep > 0 && reply_q.size() > 0)
        chk($sformatf("v%0d_rep", v), {24'd0, reply_q[0]}, {24'd0, vecs[v].rep});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_ready", v), {31'd0, mc_ready}, 32'd1);
    end
    chk("engine_protocol_viol", viol, 0);

    // reply FIFO full holds off the request
    prim_log.delete();
    reply_q.delete();
    eng_rdata = 8'hC3;
    rsp_full = 1'b1;
    mc_op = 3'd4; mc_addr = 16'h0; mc_data = 8'h0; mc_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("full_mc_ready", {31'd0, mc_ready}, 32'd0);
    chk("full_no_prim", prim_log.size(), 0);
    chk("full_busy", {31'd0, busy}, 32'd0);
    rsp_full = 1'b0;
    #1 chk("full_release_ready", {31'd0, mc_ready}, 32'd1);
    @(posedge clk);
    #1 mc_valid = 1'b0;
    @(negedge clk);
    chk("full_first_cmd", {28'd0, prim_cmd}, 32'd2);
    chk("full_first_dat", {24'd0, prim_data}, 32'hE4);
    chk("full_busy_on", {31'd0, busy}, 32'd1);
    wait_idle("full");
    chk("full_nrep", reply_q.size(), 1);
    if (reply_q.size() > 0) chk("full_rep", {24'd0, reply_q[0]}, 32'hC3);

    // engine never returns ready after the first WRITE
    prim_log.delete();
    reply_q.delete();
    stall_en = 1'b1;
    stall_idx = 0;
    send_macro(3'd1, 16'h4321, 8'h00);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (err_timeout) begin n = i; seen = 1'b1; break; end
    end
    chk("tmo_seen", {31'd0, seen}, 32'd1);
    chk("tmo_within_102", {31'd0, (n >= 100 && n <= 103)}, 32'd1);
    chk("tmo_wr_en", {31'd0, rsp_wr_en}, 32'd1);
    chk("tmo_rsp", {24'd0, rsp_data}, 32'hEE);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_ready", {31'd0, mc_ready}, 32'd1);
    chk("tmo_nprim", prim_log.size(), 1);
    if (prim_log.size() > 0) chk("tmo_prim0", {20'd0, prim_log[0]}, 32'h2E0);
    prim_ready = 1'b1;
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    // opcode 7 timing, and err_timeout stays sticky
    reply_q.delete();
    mc_op = 3'd7; mc_valid = 1'b1;
    @(posedge clk);
    #1 mc_valid = 1'b0;
    @(negedge clk);
    chk("op7_wr_en", {31'd0, rsp_wr_en}, 32'd1);
    chk("op7_rsp", {24'd0, rsp_data}, 32'hEF);
    chk("op7_idle", {31'd0, mc_ready}, 32'd1);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    @(negedge clk);
    chk("op7_single_pulse", {31'd0, rsp_wr_en}, 32'd0);

    // reset mid READ_STATUS with a reply byte about to be written
    prim_log.delete();
    reply_q.delete();
    stall_en = 1'b1;
    stall_idx = 1;
    eng_rdata = 8'h99;
    send_macro(3'd4, 16'h0, 8'h0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (prim_log.size() >= 2) begin seen = 1'b1; break; end
    end
    chk("rstm_read_issued", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("rstm_busy", {31'd0, busy}, 32'd1);
    #2 prim_rvalid = 1'b1;
    prim_rdata = 8'h99;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rstm_drop_wr", {31'd0, rsp_wr_en}, 32'd0);
    @(negedge clk);
    chk("rstm_prim_cmd", {28'd0, prim_cmd}, 32'd0);
    chk("rstm_prim_data", {24'd0, prim_data}, 32'd0);
    chk("rstm_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rstm_busy_off", {31'd0, busy}, 32'd0);
    chk("rstm_err", {31'd0, err_timeout}, 32'd0);
    prim_ready = 1'b1;
    stall_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstm_ready", {31'd0, mc_ready}, 32'd1);
    chk("rstm_no_reply", reply_q.size(), 0);
    chk("rstm_no_more_prims", prim_log.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
